// File: rtl/uart_echo_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_echo_pkg
// Purpose  : Shared encodings and the per-byte transform for uart_echo_fifo.
//            Mode encodings (pass/add/xor/bit-reverse), TX FSM states and a
//            width-generic transform function.
// Revision : 1.0 - initial release
// ============================================================================
package uart_echo_pkg;

  typedef enum logic [1:0] {
    MODE_PASS = 2'd0,
    MODE_ADD  = 2'd1,
    MODE_XOR  = 2'd2,
    MODE_REV  = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    TX_IDLE = 2'd0,
    TX_SEND = 2'd1,
    TX_WAIT = 2'd2
  } tx_state_e;

  // The transform works on a fixed container width so a package function
  // can serve any DATA_WIDTH up to this limit; the caller truncates.
  localparam int XFORM_MAX_W = 32;

  function automatic logic [XFORM_MAX_W-1:0] transform(
    input logic [XFORM_MAX_W-1:0] data,
    input logic [1:0]             mode,
    input int unsigned            width,
    input logic [XFORM_MAX_W-1:0] add_c,
    input logic [XFORM_MAX_W-1:0] xor_m
  );
    logic [XFORM_MAX_W-1:0] r;
    logic [XFORM_MAX_W-1:0] mask;
    logic [4:0]             src;
    mask = (width >= XFORM_MAX_W) ? '1
         : ((XFORM_MAX_W'(1) << width) - XFORM_MAX_W'(1));
    r    = data;
    src  = '0;
    case (mode)
      MODE_ADD: r = data + add_c;   // carry beyond width removed by mask
      MODE_XOR: r = data ^ xor_m;
      MODE_REV: begin
        r = '0;
        for (int i = 0; i < XFORM_MAX_W; i++) begin
          if (i < width) begin
            src        = 5'(width - 1 - i);
            r[5'(i)]   = data[src];
          end
        end
      end
      default:  r = data;
    endcase
    return r & mask;
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_echo_fifo_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module   : sync_fifo
// Purpose  : Single-clock FIFO with occupancy counter; full/empty derive
//            from the level. A push while full is accepted only when a pop
//            happens on the same edge.
// Ports    : clk, rst (async, active-high), push, pop, wdata -> rdata
//            (head, combinational), level, full, empty
// Revision : 1.0 - initial release
// ============================================================================
module sync_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          push,
  input  logic                          pop,
  input  logic [DATA_WIDTH-1:0]         wdata,
  output logic [DATA_WIDTH-1:0]         rdata,
  output logic [$clog2(FIFO_DEPTH):0]   level,
  output logic                          full,
  output logic                          empty
);
  localparam int c_addr_w = $clog2(FIFO_DEPTH);
  localparam int c_lvl_w  = c_addr_w + 1;
  localparam logic [c_lvl_w-1:0] c_fifo_depth = c_lvl_w'(FIFO_DEPTH);

  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [c_addr_w-1:0]   wr_ptr_q;
  logic [c_addr_w-1:0]   rd_ptr_q;
  logic [c_lvl_w-1:0]    level_q;
  logic                  w_push_ok;
  logic                  w_pop_ok;

  assign full      = (level_q == c_fifo_depth);
  assign empty     = (level_q == '0);
  assign w_pop_ok  = pop & ~empty;
  assign w_push_ok = push & (~full | w_pop_ok);
  assign rdata     = mem_q[rd_ptr_q];
  assign level     = level_q;

  always_ff @(posedge clk) begin
    if (w_push_ok) mem_q[wr_ptr_q] <= wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (w_push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (w_pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({w_push_ok, w_pop_ok})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
    end
  end
endmodule
`default_nettype wire

// File: rtl/uart_echo_fifo.sv
`default_nettype none
// ============================================================================
// Module   : uart_echo_fifo
// Purpose  : Buffers bytes from uart_rx in a FIFO, applies a per-byte
//            transform and drains them to uart_tx with a start/done handshake.
// Ports    : rx_ready/rx_error/rx_data/mode in; tx_data/tx_start out,
//            tx_done in; ovf_clr in, overflow out (sticky); fifo_level, led.
// Options  : UART_ECHO_STATS_EN adds rx_count, drop_count, tx_count (16-bit
//            saturating) and shows rx_count on led while the FIFO is empty.
// Revision : 1.0 - initial release
// ============================================================================
module uart_echo_fifo
  import uart_echo_pkg::*;
#(
  parameter int                    DATA_WIDTH = 8,
  parameter int                    FIFO_DEPTH = 16,
  parameter int                    ADD_CONST  = 1,
  parameter logic [DATA_WIDTH-1:0] XOR_MASK   = 8'h20
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        rx_ready,
  input  logic                        rx_error,
  input  logic [DATA_WIDTH-1:0]       rx_data,
  input  logic [1:0]                  mode,
  output logic [DATA_WIDTH-1:0]       tx_data,
  output logic                        tx_start,
  input  logic                        tx_done,
  input  logic                        ovf_clr,
  output logic                        overflow,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  output logic [DATA_WIDTH-1:0]       led
`ifdef UART_ECHO_STATS_EN
  ,
  output logic [15:0]                 rx_count,
  output logic [15:0]                 drop_count,
  output logic [15:0]                 tx_count
`endif
);
  logic                  rx_ready_q;
  logic                  w_rx_edge;
  logic                  w_push_req;
  logic                  w_push_ok;
  logic                  w_drop;
  logic                  w_pop;
  logic                  w_full;
  logic                  w_empty;
  logic [DATA_WIDTH-1:0] w_push_data;
  logic [DATA_WIDTH-1:0] w_fifo_rdata;
  tx_state_e             state_q, state_d;
  logic [DATA_WIDTH-1:0] tx_data_q, tx_data_d;
  logic                  tx_start_q, tx_start_d;
  logic                  overflow_q, overflow_d;
  logic [DATA_WIDTH-1:0] led_q;

  // A held rx_ready level produces a single push on its rising edge.
  assign w_rx_edge   = rx_ready & ~rx_ready_q;
  assign w_push_req  = w_rx_edge & ~rx_error;
  assign w_push_data = DATA_WIDTH'(transform(XFORM_MAX_W'(rx_data), mode,
                         DATA_WIDTH, XFORM_MAX_W'(ADD_CONST),
                         XFORM_MAX_W'(XOR_MASK)));
  // A simultaneous pop frees the slot, so a push while full is not a drop.
  assign w_push_ok   = w_push_req & (~w_full | w_pop);
  assign w_drop      = w_push_req & w_full & ~w_pop;

  // Drop-set takes priority over a coincident clear.
  assign overflow_d  = w_drop ? 1'b1 : (ovf_clr ? 1'b0 : overflow_q);

  sync_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (w_push_ok),
    .pop   (w_pop),
    .wdata (w_push_data),
    .rdata (w_fifo_rdata),
    .level (fifo_level),
    .full  (w_full),
    .empty (w_empty)
  );

  // tx_start is registered and rises one cycle after the head is loaded,
  // so tx_data is already settled when uart_tx sees the request.
  always_comb begin
    state_d    = state_q;
    tx_data_d  = tx_data_q;
    tx_start_d = 1'b0;
    w_pop      = 1'b0;
    case (state_q)
      TX_IDLE: begin
        if (!w_empty) begin
          w_pop     = 1'b1;
          tx_data_d = w_fifo_rdata;
          state_d   = TX_SEND;
        end
      end
      TX_SEND: begin
        // Only honour done once the request has actually been presented.
        if (tx_start_q && tx_done) state_d    = TX_WAIT;
        else                       tx_start_d = 1'b1;
      end
      TX_WAIT: begin
        if (!tx_done) state_d = TX_IDLE;
      end
      default: state_d = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_ready_q <= 1'b0;
      state_q    <= TX_IDLE;
      tx_data_q  <= '0;
      tx_start_q <= 1'b0;
      overflow_q <= 1'b0;
      led_q      <= '0;
    end else begin
      rx_ready_q <= rx_ready;
      state_q    <= state_d;
      tx_data_q  <= tx_data_d;
      tx_start_q <= tx_start_d;
      overflow_q <= overflow_d;
      if (w_rx_edge) led_q <= rx_error ? '1 : rx_data;
    end
  end

  assign tx_data  = tx_data_q;
  assign tx_start = tx_start_q;
  assign overflow = overflow_q;

`ifdef UART_ECHO_STATS_EN
  logic [15:0] rx_count_q;
  logic [15:0] drop_count_q;
  logic [15:0] tx_count_q;
  logic        w_sent;

  assign w_sent = (state_q == TX_SEND) && (state_d == TX_WAIT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_count_q   <= '0;
      drop_count_q <= '0;
      tx_count_q   <= '0;
    end else begin
      if (w_push_ok && rx_count_q != 16'hFFFF)
        rx_count_q <= rx_count_q + 16'd1;
      if ((w_drop || (w_rx_edge && rx_error)) && drop_count_q != 16'hFFFF)
        drop_count_q <= drop_count_q + 16'd1;
      if (w_sent && tx_count_q != 16'hFFFF)
        tx_count_q <= tx_count_q + 16'd1;
    end
  end

  assign rx_count   = rx_count_q;
  assign drop_count = drop_count_q;
  assign tx_count   = tx_count_q;
  assign led        = w_empty ? rx_count_q[DATA_WIDTH-1:0] : led_q;
`else
  assign led        = led_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_uart_echo_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_echo_fifo
// Purpose  : Directed-vector bench for uart_echo_fifo with an expected-byte
//            scoreboard checked whenever tx_start rises, plus a simple
//            uart_tx responder that can be stalled.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_echo_fifo;
  localparam int DW    = 8;
  localparam int DEPTH = 16;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          rx_ready;
  logic          rx_error;
  logic [DW-1:0] rx_data;
  logic [1:0]    mode;
  logic [DW-1:0] tx_data;
  logic          tx_start;
  logic          tx_done;
  logic          ovf_clr;
  logic          overflow;
  logic [LW-1:0] fifo_level;
  logic [DW-1:0] led;

  int            n_vec = 0;
  int            n_err = 0;
  logic [7:0]    exp_q[$];
  bit            stall = 1'b0;

  uart_echo_fifo #(
    .DATA_WIDTH (DW),
    .FIFO_DEPTH (DEPTH),
    .ADD_CONST  (1),
    .XOR_MASK   (8'h20)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .rx_ready   (rx_ready),
    .rx_error   (rx_error),
    .rx_data    (rx_data),
    .mode       (mode),
    .tx_data    (tx_data),
    .tx_start   (tx_start),
    .tx_done    (tx_done),
    .ovf_clr    (ovf_clr),
    .overflow   (overflow),
    .fifo_level (fifo_level),
    .led        (led)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic [1:0] m, input logic err,
                           input bit exp_push, input logic [7:0] e);
    @(negedge clk);
    rx_data  = b;
    mode     = m;
    rx_error = err;
    rx_ready = 1'b1;
    if (exp_push) exp_q.push_back(e);
    @(negedge clk);
    rx_ready = 1'b0;
    rx_error = 1'b0;
  endtask

  task automatic drain(input int budget);
    int k;
    k = 0;
    while ((exp_q.size() != 0 || fifo_level != '0 || tx_start || tx_done) && k < budget) begin
      @(negedge clk);
      k++;
    end
    n_vec++;
    if (k >= budget) begin
      n_err++;
      $display("FAIL drain: timeout with %0d bytes outstanding, expected 0", exp_q.size());
    end
  endtask

  // uart_tx responder: answers a start with done after two cycles, holds done
  // until start drops.
  initial begin
    int cnt;
    cnt     = 0;
    tx_done = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        tx_done = 1'b0;
        cnt     = 0;
      end else if (tx_done) begin
        if (!tx_start) tx_done = 1'b0;
      end else if (tx_start && !stall) begin
        cnt++;
        if (cnt == 2) begin
          tx_done = 1'b1;
          cnt     = 0;
        end
      end
    end
  end

  // Scoreboard monitor: each new transmit request must carry the next byte.
  initial begin
    logic       prev;
    logic [7:0] e;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (tx_start && !prev) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_tx: got tx_data 0x%0h, expected no transmit", tx_data);
        end else begin
          e = exp_q.pop_front();
          check("tx_data", 32'(tx_data), 32'(e));
        end
      end
      prev = tx_start;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    rst      = 1'b1;
    rx_ready = 1'b0;
    rx_error = 1'b0;
    rx_data  = '0;
    mode     = 2'd0;
    ovf_clr  = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_tx_start", 32'(tx_start), 32'd0);
    check("rst_tx_data", 32'(tx_data), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_led", 32'(led), 32'd0);
    check("rst_level", 32'(fifo_level), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Single byte, add mode, latency.
    @(negedge clk);
    rx_data = 8'h41; mode = 2'd1; rx_ready = 1'b1;
    exp_q.push_back(8'h42);
    @(negedge clk);
    rx_ready = 1'b0;
    check("lat_level_push", 32'(fifo_level), 32'd1);
    check("lat_start_n", 32'(tx_start), 32'd0);
    @(negedge clk);
    check("lat_level_pop", 32'(fifo_level), 32'd0);
    check("lat_start_n1", 32'(tx_start), 32'd0);
    check("lat_tx_data", 32'(tx_data), 32'h42);
    @(negedge clk);
    check("lat_start_n2", 32'(tx_start), 32'd1);
    check("led_raw", 32'(led), 32'h41);
    drain(100);
    check("single_level_end", 32'(fifo_level), 32'd0);

    // Burst of five with transmitter stalled.
    stall = 1'b1;
    for (int i = 1; i <= 5; i++) send_byte(8'(i), 2'd1, 1'b0, 1'b1, 8'(i + 1));
    check("burst_level", 32'(fifo_level), 32'd4);
    check("burst_overflow", 32'(overflow), 32'd0);
    stall = 1'b0;
    drain(200);
    check("burst_overflow_end", 32'(overflow), 32'd0);

    // Fill to DEPTH (+1 held in tx_data), then one drop.
    stall = 1'b1;
    for (int i = 0; i < DEPTH + 1; i++) send_byte(8'(8'h10 + i), 2'd0, 1'b0, 1'b1, 8'(8'h10 + i));
    check("full_level", 32'(fifo_level), 32'(DEPTH));
    check("full_no_ovf", 32'(overflow), 32'd0);
    send_byte(8'hEE, 2'd0, 1'b0, 1'b0, 8'h00);
    check("drop_level", 32'(fifo_level), 32'(DEPTH));
    check("drop_overflow", 32'(overflow), 32'd1);
    @(negedge clk);
    ovf_clr = 1'b1;
    @(negedge clk);
    ovf_clr = 1'b0;
    check("ovf_clr", 32'(overflow), 32'd0);
    stall = 1'b0;
    drain(1000);

    // Transforms.
    send_byte(8'h81, 2'd2, 1'b0, 1'b1, 8'hA1);
    send_byte(8'h81, 2'd3, 1'b0, 1'b1, 8'h81);
    send_byte(8'hFF, 2'd1, 1'b0, 1'b1, 8'h00);
    send_byte(8'h5A, 2'd0, 1'b0, 1'b1, 8'h5A);
    send_byte(8'h01, 2'd3, 1'b0, 1'b1, 8'h80);
    drain(300);

    // Framing error: discarded, led all ones.
    send_byte(8'h33, 2'd0, 1'b1, 1'b0, 8'h00);
    check("err_led", 32'(led), 32'hFF);
    check("err_level", 32'(fifo_level), 32'd0);
    repeat (6) @(negedge clk);
    check("err_no_start", 32'(tx_start), 32'd0);
    check("err_no_ovf", 32'(overflow), 32'd0);

    // Reset during a transmit with three bytes queued.
    stall = 1'b1;
    for (int i = 0; i < 4; i++) send_byte(8'(8'hA0 + i), 2'd0, 1'b0, 1'b1, 8'(8'hA0 + i));
    k = 0;
    while (!tx_start && k < 20) begin
      @(negedge clk);
      k++;
    end
    check("mid_start_before", 32'(tx_start), 32'd1);
    check("mid_level_before", 32'(fifo_level), 32'd3);
    #1 rst = 1'b1;
    #1;
    check("mid_rst_start", 32'(tx_start), 32'd0);
    check("mid_rst_level", 32'(fifo_level), 32'd0);
    check("mid_rst_txdata", 32'(tx_data), 32'd0);
    exp_q.delete();
    @(negedge clk);
    @(negedge clk);
    rst   = 1'b0;
    stall = 1'b0;
    repeat (20) @(negedge clk);
    check("post_rst_start", 32'(tx_start), 32'd0);
    check("post_rst_level", 32'(fifo_level), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/uart_echo_fifo.md
Name: uart_echo_fifo

Overview:
Parametrised successor to the single-byte UART echo loop. Sits between existing uart_rx and uart_tx instances. Buffers received bytes in a FIFO, applies a selectable per-byte transform, and drains the FIFO to the transmitter with a start/done handshake. Drives an LED status word and a sticky overflow flag, so back-to-back input bytes are no longer lost while a transmit is in progress.

Parameters:
DATA_WIDTH, 8, byte width on rx/tx/led paths
FIFO_DEPTH, 16, FIFO entries; power of two, min 2
ADD_CONST, 1, addend for MODE_ADD
XOR_MASK, 8'h20, mask for MODE_XOR

Ports:
clk  in  1  system clock, rising edge
rst  in  1  reset, asynchronous, active-high
rx_ready  in  1  level from uart_rx; high while a received byte is valid
rx_error  in  1  framing error from uart_rx
rx_data  in  DATA_WIDTH  received byte
mode  in  2  transform select: 0 pass, 1 add, 2 xor, 3 bit-reverse
tx_data  out  DATA_WIDTH  byte to uart_tx
tx_start  out  1  transmit request to uart_tx
tx_done  in  1  transmit-complete from uart_tx
ovf_clr  in  1  clears sticky overflow
overflow  out  1  sticky: a byte was dropped because the FIFO was full
fifo_level  out  $clog2(FIFO_DEPTH)+1  current occupancy
led  out  DATA_WIDTH  status display

Behaviour:
- Reset (async assert, sync release): FIFO empty, fifo_level=0, tx_start=0, tx_data=0, overflow=0, led=0, TX FSM=IDLE, rx_ready edge register=0.
- Ingress: the rising edge of rx_ready (registered previous value) is the push event; a held level pushes once only.
  - If rx_error=1 on the edge cycle: discard the byte; set led to all-ones.
  - Otherwise: the transform is computed combinationally from the mode value sampled on that cycle, and the result is pushed.
  - The led register takes the raw rx_data.
- Transforms: add is modulo 2^DATA_WIDTH (the carry is discarded); xor uses XOR_MASK; bit-reverse swaps bit i with bit DATA_WIDTH-1-i.
- Full: a push while fifo_level==FIFO_DEPTH is dropped and sets overflow. A push and pop in the same cycle while full is accepted and the level is unchanged.
- Overflow clearing: ovf_clr clears overflow one cycle later. If ovf_clr and a new drop coincide, the set wins.
- TX FSM:
  - IDLE: when the FIFO is not empty, pop the head into tx_data and go to SEND. The pop and tx_data load happen on that same edge.
  - SEND: tx_start=1; tx_data is held stable; on tx_done=1 go to WAIT.
  - WAIT: tx_start=0; on tx_done=0 go to IDLE.
  - Latency: an empty FIFO with a push at edge N gives tx_start high after edge N+2 (push at N, pop at N+1).
- Empty: no pop; the FSM stays in IDLE.
- fifo_level updates on the same edge as the push or pop.
- Reset mid-transmit: tx_start drops immediately (async), and queued bytes are lost.
- Pointers are $clog2(FIFO_DEPTH) bits and wrap naturally. Full/empty are derived from fifo_level.

Optional Feature:
UART_ECHO_STATS_EN
- Defined: adds outputs rx_count (16 bits, counts accepted pushes), drop_count (16 bits, counts overflow drops plus error discards) and tx_count (16 bits, increments on the SEND->WAIT transition).
  - All three counters saturate at 16'hFFFF and reset to 0.
  - led shows rx_count[DATA_WIDTH-1:0] whenever the FIFO is empty.
- Undefined: these ports and counters do not exist, and led behaves as described above.

Decomposition:
- Package uart_echo_pkg holds:
  - mode encodings MODE_PASS=0, MODE_ADD=1, MODE_XOR=2, MODE_REV=3;
  - TX FSM state encodings TX_IDLE, TX_SEND, TX_WAIT;
  - a transform function taking (data, mode).
- One sub-module, sync_fifo: parameters DATA_WIDTH and FIFO_DEPTH; ports push, pop, wdata, rdata, level, full, empty; single clock; same async reset.

Test Plan:
- Single byte 8'h41, mode=1 -> tx_data=8'h42, tx_start high 2 cycles after the rx_ready edge; after done, FIFO empty and level=0.
- 5 bytes 8'h01..8'h05 arrive back-to-back while tx_done is held low -> level reaches 4 (one byte already in tx_data); bytes are sent in order 02..06 as done pulses arrive; overflow=0.
- FIFO_DEPTH+2 bytes with the transmitter stalled -> exactly one byte dropped, overflow=1, level=FIFO_DEPTH; ovf_clr pulse -> overflow=0.
- Mode checks on byte 8'h81: mode=2 -> 8'hA1; mode=3 -> 8'h81; mode=1 with byte 8'hFF -> 8'h00.
- rx_error=1 on the edge with byte 8'h33 -> no push, led=8'hFF, tx_start stays 0.
- rst asserted while tx_start=1 with 3 bytes queued -> tx_start=0 asynchronously, level=0, and no transmit after release.
